onehot_pack: RTL and testbench

Inverse of the MSB-first bit-position finder that sits on the same source/sink handshake. Accepts a stream of bit indices over a valid/ready interface, ORs each index into an accumulating WIDTH-bit vector, and emits the vector when a beat flagged `last_in` is accepted. A small output FIFO decouples packing from the downstream sink, so a new packet can begin while earlier packets wait.

---
 rtl/onehot_pack.sv | 102 ++++++++++
 tb/tb_onehot_pack.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_pack.sv
// onehot_pack: ORs a stream of bit indices into a WIDTH-bit vector per packet
// and queues each finished vector, plus a repeated-index flag, in a small FIFO.
module onehot_pack #(
    parameter int WIDTH     = 8,
    parameter int IDX_W     = $clog2(WIDTH),
    parameter int OUT_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vld_src,
    input  logic [IDX_W-1:0] index_in,
    input  logic             last_in,
    output logic             rdy_src,
    output logic [WIDTH-1:0] data_out,
    output logic             dup_out,
    output logic             vld_sink,
    input  logic             rdy_sink
);

    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CNT_W = $clog2(OUT_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OUT_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUT_DEPTH - 1);

    logic [WIDTH-1:0] r_acc;
    logic             r_dup;
    logic [WIDTH-1:0] r_mem_data [OUT_DEPTH];
    logic             r_mem_dup  [OUT_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_full;
    logic             w_acc_fire;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_onehot;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_dup_next;

    // Ready comes only from registered occupancy; no pop-to-push bypass.
    assign w_full     = (r_count == FULL_CNT);
    assign rdy_src    = ~w_full;
    assign vld_sink   = (r_count != '0);
    assign w_acc_fire = vld_src & rdy_src;
    assign w_push     = w_acc_fire & last_in;
    assign w_pop      = vld_sink & rdy_sink;

    assign w_onehot   = {{(WIDTH-1){1'b0}}, 1'b1} << index_in;
    assign w_acc_next = r_acc | w_onehot;
    assign w_dup_next = r_dup | r_acc[index_in];

    assign data_out   = r_mem_data[r_rd_ptr];
    assign dup_out    = r_mem_dup[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc <= '0;
            r_dup <= 1'b0;
        end else if (w_acc_fire) begin
            if (last_in) begin
                r_acc <= '0;
                r_dup <= 1'b0;
            end else begin
                r_acc <= w_acc_next;
                r_dup <= w_dup_next;
            end
        end
    end

    // Storage is reset so the head reads zero before the first packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < OUT_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_dup[i]  <= 1'b0;
            end
        end else if (w_push) begin
            r_mem_data[r_wr_ptr] <= w_acc_next;
            r_mem_dup[r_wr_ptr]  <= w_dup_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_onehot_pack.sv
// Bench for onehot_pack: directed vector table, reset corner case, then
// random traffic against a queue-based packet model.
module tb_onehot_pack;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             vld_src = 1'b0;
    logic [IDX_W-1:0] index_in = '0;
    logic             last_in = 1'b0;
    logic             rdy_src;
    logic [WIDTH-1:0] data_out;
    logic             dup_out;
    logic             vld_sink;
    logic             rdy_sink = 1'b0;

    onehot_pack #(.WIDTH(WIDTH), .IDX_W(IDX_W), .OUT_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .vld_src(vld_src), .index_in(index_in),
        .last_in(last_in), .rdy_src(rdy_src), .data_out(data_out),
        .dup_out(dup_out), .vld_sink(vld_sink), .rdy_sink(rdy_sink)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         vld;
        int         idx;
        bit         last;
        bit         rs;
        bit         e_rdy;
        bit         e_vld;
        logic [7:0] e_data;
        bit         e_dup;
    } vec_t;
    vec_t tbl[$];

    typedef struct {
        logic [7:0] d;
        bit         dup;
    } ent_t;
    ent_t q[$];
    bit   seen[WIDTH];
    bit   mdup;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic add(input bit vld, input int idx, input bit last, input bit rs,
                       input bit e_rdy, input bit e_vld, input logic [7:0] e_data, input bit e_dup);
        vec_t v;
        v.vld = vld; v.idx = idx; v.last = last; v.rs = rs;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_dup = e_dup;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        q.delete();
        mdup = 1'b0;
        for (int i = 0; i < WIDTH; i++) seen[i] = 1'b0;
    endtask

    // Advance one clock and apply the packet rules to the model.
    task automatic tick();
        bit   f, p, lv;
        int   iv;
        ent_t e;
        f  = vld_src && (q.size() < DEPTH);
        p  = (q.size() != 0) && rdy_sink;
        iv = int'(index_in);
        lv = last_in;
        @(posedge clk);
        #1;
        if (p) void'(q.pop_front());
        if (f) begin
            if (seen[iv]) mdup = 1'b1;
            seen[iv] = 1'b1;
            if (lv) begin
                e.d = 8'd0;
                for (int i = 0; i < WIDTH; i++) if (seen[i]) e.d = e.d + 8'(2 ** i);
                e.dup = mdup;
                q.push_back(e);
                model_reset_acc();
            end
        end
    endtask

    task automatic model_reset_acc();
        mdup = 1'b0;
        for (int i = 0; i < WIDTH; i++) seen[i] = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " rdy_src"}, 32'(rdy_src), 32'(q.size() < DEPTH));
        chk({tag, " vld_sink"}, 32'(vld_sink), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk({tag, " data_out"}, 32'(data_out), 32'(q[0].d));
            chk({tag, " dup_out"}, 32'(dup_out), 32'(q[0].dup));
        end
    endtask

    initial begin
        model_reset();

        // Reset state
        #3;
        chk("reset rdy_src", 32'(rdy_src), 32'd1);
        chk("reset vld_sink", 32'(vld_sink), 32'd0);
        chk("reset data_out", 32'(data_out), 32'h00);
        chk("reset dup_out", 32'(dup_out), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Directed vectors; expectations are pre-edge outputs of each row.
        add(0, 0, 0, 1, 1, 0, 8'h00, 0);
        add(1, 7, 0, 1, 1, 0, 8'h00, 0);
        add(1, 3, 0, 1, 1, 0, 8'h00, 0);
        add(1, 0, 1, 1, 1, 0, 8'h00, 0);
        add(0, 0, 0, 1, 1, 1, 8'h89, 0);
        add(0, 0, 0, 1, 1, 0, 8'h00, 0);
        add(1, 5, 0, 1, 1, 0, 8'h00, 0);
        add(1, 5, 1, 1, 1, 0, 8'h00, 0);
        add(1, 1, 1, 1, 1, 1, 8'h20, 1);
        add(0, 0, 0, 1, 1, 1, 8'h02, 0);
        add(0, 0, 0, 0, 1, 0, 8'h00, 0);
        add(1, 2, 1, 0, 1, 0, 8'h00, 0);
        add(1, 4, 1, 0, 1, 1, 8'h04, 0);
        add(1, 6, 1, 0, 0, 1, 8'h04, 0);
        add(1, 6, 1, 1, 0, 1, 8'h04, 0);
        add(1, 6, 1, 1, 1, 1, 8'h10, 0);
        add(0, 0, 0, 1, 1, 1, 8'h40, 0);
        add(0, 0, 0, 1, 1, 0, 8'h00, 0);
        add(1, 3, 1, 1, 1, 0, 8'h00, 0);
        for (int k = 0; k < 8; k++)
            add(1, k, 1, 1, 1, 1, (k == 0) ? 8'h08 : 8'(2 ** (k - 1)), 0);
        add(0, 0, 0, 1, 1, 1, 8'h80, 0);
        add(0, 0, 0, 1, 1, 0, 8'h00, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            vld_src  = tbl[i].vld;
            index_in = IDX_W'(tbl[i].idx);
            last_in  = tbl[i].last;
            rdy_sink = tbl[i].rs;
            #1;
            chk($sformatf("row%0d rdy_src", i), 32'(rdy_src), 32'(tbl[i].e_rdy));
            chk($sformatf("row%0d vld_sink", i), 32'(vld_sink), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                chk($sformatf("row%0d data_out", i), 32'(data_out), 32'(tbl[i].e_data));
                chk($sformatf("row%0d dup_out", i), 32'(dup_out), 32'(tbl[i].e_dup));
            end
            tick();
        end

        // Reset with a queued entry and a partial packet in flight.
        rdy_sink = 1'b0;
        vld_src = 1'b1; index_in = 3'd3; last_in = 1'b1; tick();
        index_in = 3'd6; last_in = 1'b0; tick();
        index_in = 3'd1; tick();
        vld_src = 1'b0;
        rst = 1'b0;
        #2;
        chk("midrst rdy_src", 32'(rdy_src), 32'd1);
        chk("midrst vld_sink", 32'(vld_sink), 32'd0);
        chk("midrst data_out", 32'(data_out), 32'h00);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        rdy_sink = 1'b1;
        vld_src = 1'b1; index_in = 3'd0; last_in = 1'b1; tick();
        vld_src = 1'b0;
        #1;
        chk("postrst vld_sink", 32'(vld_sink), 32'd1);
        chk("postrst data_out", 32'(data_out), 32'h01);
        chk("postrst dup_out", 32'(dup_out), 32'd0);
        tick();
        #1;
        chk("postrst drained", 32'(vld_sink), 32'd0);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            vld_src  = ($urandom_range(0, 3) != 0);
            index_in = IDX_W'($urandom_range(0, WIDTH - 1));
            last_in  = ($urandom_range(0, 2) == 0);
            rdy_sink = ($urandom_range(0, 3) != 0) ^ (n[9] & ($urandom_range(0, 1) == 0));
            #1;
            chk_model($sformatf("rnd%0d", n));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
